// File: rtl/iic_pkg.sv
// Shared types and helpers for the IIC arbiter slice.
//   arb_state_t : arbiter FSM states
//   reg_w()     : register-address width for a given extension setting
package iic_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4
  } arb_state_t;

  // 0 -> 8-bit register address, 1 -> 16-bit register address
  function automatic int unsigned reg_w(input int unsigned ex);
    return 8 + 8 * ex;
  endfunction

endpackage

// File: rtl/iic_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   req     : request vector
//   ptr     : index with highest priority this round
//   grant_c : one-hot grant of the first set request at or after ptr (cyclic)
//   idx_c   : binary index of the granted request
//   any_c   : at least one request is set
module rr_picker #(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant_c,
  output logic [PW-1:0] idx_c,
  output logic          any_c
);

  logic hit;

  // First pass searches [ptr, N-1]; second pass wraps to [0, ptr-1].
  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    hit     = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!hit && req[i] && (i >= 32'(ptr))) begin
        hit        = 1'b1;
        grant_c[i] = 1'b1;
        idx_c      = PW'(i);
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!hit && req[i]) begin
        hit        = 1'b1;
        grant_c[i] = 1'b1;
        idx_c      = PW'(i);
      end
    end
    any_c = hit;
  end

endmodule

// File: rtl/iic_arbiter.sv
// Round-robin arbiter sharing one single-byte iic_master between NUM_REQ clients.
//   req_*       : per-requester command (valid/rw/slave/addr/wdata), ack pulse on latch
//   rsp_*       : completion pulse to the granted requester with error flag and read byte
//   arb_busy    : arbiter not idle
//   iic_start   : one-cycle start pulse to iic_master
//   iic_busy    : transfer-in-progress from iic_master
//   m_*         : latched command to iic_master, held from START until IDLE
//   m_recv_data : read byte from iic_master
module iic_arbiter
  import iic_pkg::*;
#(
  parameter int unsigned NUM_REQ          = 2,
  parameter int unsigned IIC_SLAVE_REG_EX = 1,
  parameter int unsigned BUSY_TIMEOUT     = 64
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [NUM_REQ-1:0]                           req_valid,
  output logic [NUM_REQ-1:0]                           req_ack,
  input  logic [NUM_REQ-1:0]                           req_rw,
  input  logic [NUM_REQ*8-1:0]                         req_slave,
  input  logic [NUM_REQ*reg_w(IIC_SLAVE_REG_EX)-1:0]   req_addr,
  input  logic [NUM_REQ*8-1:0]                         req_wdata,
  output logic [NUM_REQ-1:0]                           rsp_valid,
  output logic                                         rsp_err,
  output logic [7:0]                                   rsp_rdata,
  output logic                                         arb_busy,
  output logic                                         iic_start,
  input  logic                                         iic_busy,
  output logic [7:0]                                   m_slave,
  output logic                                         m_rw,
  output logic [reg_w(IIC_SLAVE_REG_EX)-1:0]           m_reg_addr,
  output logic [7:0]                                   m_send_data,
  input  logic [7:0]                                   m_recv_data
);

  localparam int unsigned REG_W = reg_w(IIC_SLAVE_REG_EX);
  localparam int unsigned PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW    = $clog2(BUSY_TIMEOUT + 1);

  arb_state_t           state;
  logic [PW-1:0]        ptr;
  logic [PW-1:0]        gidx;
  logic [CW-1:0]        cnt;

  logic [NUM_REQ-1:0]   grant_c;
  logic [PW-1:0]        pick_c;
  logic                 any_c;
  logic [CW-1:0]        cnt_inc_c;

  assign cnt_inc_c = cnt + CW'(1);

  rr_picker #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr_picker (
    .req     (req_valid),
    .ptr     (ptr),
    .grant_c (grant_c),
    .idx_c   (pick_c),
    .any_c   (any_c)
  );

  // Arbiter FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      gidx        <= '0;
      cnt         <= '0;
      req_ack     <= '0;
      rsp_valid   <= '0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= '0;
      arb_busy    <= 1'b0;
      iic_start   <= 1'b0;
      m_slave     <= '0;
      m_rw        <= 1'b0;
      m_reg_addr  <= '0;
      m_send_data <= '0;
    end else begin
      req_ack   <= '0;
      rsp_valid <= '0;
      iic_start <= 1'b0;

      case (state)
        IDLE: begin
          // A transfer still running in the master (e.g. across reset) blocks new grants.
          if (!iic_busy && any_c) begin
            gidx        <= pick_c;
            req_ack     <= grant_c;
            m_rw        <= req_rw[pick_c];
            m_slave     <= req_slave[32'(pick_c) * 8 +: 8];
            m_reg_addr  <= req_addr[32'(pick_c) * REG_W +: REG_W];
            m_send_data <= req_wdata[32'(pick_c) * 8 +: 8];
            arb_busy    <= 1'b1;
            state       <= START;
          end
        end

        START: begin
          iic_start <= 1'b1;
          cnt       <= '0;
          state     <= WAIT_BUSY;
        end

        // cnt is 0 in the cycle iic_start is high, so the error response
        // lands exactly BUSY_TIMEOUT cycles after the start pulse.
        WAIT_BUSY: begin
          if (iic_busy) begin
            state <= WAIT_DONE;
          end else if (cnt_inc_c == CW'(BUSY_TIMEOUT)) begin
            rsp_valid[gidx] <= 1'b1;
            rsp_err         <= 1'b1;
            rsp_rdata       <= '0;
            state           <= DONE;
          end else begin
            cnt <= cnt_inc_c;
          end
        end

        WAIT_DONE: begin
          if (!iic_busy) begin
            rsp_valid[gidx] <= 1'b1;
            rsp_err         <= 1'b0;
            rsp_rdata       <= m_rw ? m_recv_data : 8'h00;
            state           <= DONE;
          end
        end

        DONE: begin
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          ptr       <= (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + PW'(1);
          arb_busy  <= 1'b0;
          state     <= IDLE;
        end

        default: begin
          arb_busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iic_arbiter.sv
// Scoreboard bench for iic_arbiter (3 requesters, 16-bit register address,
// short busy timeout) with a simple iic_master BFM: busy rises 3 cycles
// after start and lasts 20 cycles, or never rises when bfm_dead is set.
module tb_iic_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned EX = 1;
  localparam int unsigned TO = 16;
  localparam int unsigned RW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ack, req_rw, rsp_valid;
  logic [N*8-1:0]  req_slave, req_wdata;
  logic [N*RW-1:0] req_addr;
  logic            rsp_err;
  logic [7:0]      rsp_rdata;
  logic            arb_busy, iic_start, iic_busy;
  logic [7:0]      m_slave, m_send_data, m_recv_data;
  logic            m_rw;
  logic [RW-1:0]   m_reg_addr;

  always #5 clk = ~clk;

  iic_arbiter #(
    .NUM_REQ          (N),
    .IIC_SLAVE_REG_EX (EX),
    .BUSY_TIMEOUT     (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ack     (req_ack),
    .req_rw      (req_rw),
    .req_slave   (req_slave),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_err     (rsp_err),
    .rsp_rdata   (rsp_rdata),
    .arb_busy    (arb_busy),
    .iic_start   (iic_start),
    .iic_busy    (iic_busy),
    .m_slave     (m_slave),
    .m_rw        (m_rw),
    .m_reg_addr  (m_reg_addr),
    .m_send_data (m_send_data),
    .m_recv_data (m_recv_data)
  );

  // Requester model: valid while more transactions issued than acked.
  int         issued [N];
  int         acked  [N];
  logic       f_rw    [N];
  logic [7:0] f_slave [N];
  logic [15:0] f_addr [N];
  logic [7:0] f_wdata [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = (issued[i] != acked[i]);
      req_rw[i]              = f_rw[i];
      req_slave[i*8 +: 8]    = f_slave[i];
      req_addr[i*RW +: RW]   = f_addr[i];
      req_wdata[i*8 +: 8]    = f_wdata[i];
    end
  end

  // iic_master BFM
  int         bfm_t = 0;
  logic       bfm_dead;
  logic [7:0] bfm_rdata;

  always @(posedge clk) begin
    if (iic_start && !bfm_dead) bfm_t <= 1;
    else if (bfm_t == 22)       bfm_t <= 0;
    else if (bfm_t != 0)        bfm_t <= bfm_t + 1;
  end
  assign iic_busy    = (bfm_t >= 3);
  assign m_recv_data = bfm_rdata;

  // Scoreboard
  typedef struct {
    int          idx;
    logic        rw;
    logic [7:0]  slave;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } ack_t;

  typedef struct {
    int         idx;
    logic       err;
    logic [7:0] rdata;
  } rsp_t;

  ack_t ackq[$];
  rsp_t rspq[$];
  ack_t cur;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc = 0, ack_cyc = 0, start_cyc = 0;
  logic prev_busy = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_ack(input int i);
    ack_t e;
    e.idx = i; e.rw = f_rw[i]; e.slave = f_slave[i]; e.addr = f_addr[i]; e.wdata = f_wdata[i];
    ackq.push_back(e);
  endtask

  task automatic push_rsp(input int i, input logic err, input logic [7:0] rdata);
    rsp_t r;
    r.idx = i; r.err = err; r.rdata = rdata;
    rspq.push_back(r);
  endtask

  task automatic set_req(input int i, input logic rw, input logic [7:0] slave,
                         input logic [15:0] addr, input logic [7:0] wdata);
    f_rw[i] = rw; f_slave[i] = slave; f_addr[i] = addr; f_wdata[i] = wdata;
  endtask

  // One monitor step per falling edge.
  task automatic mon_step();
    logic [N-1:0] oh;
    ack_t e;
    rsp_t r;
    cyc++;
    if (!rst_n) begin
      chk("reset_outputs",
          {req_ack, rsp_valid, rsp_err, rsp_rdata, arb_busy, iic_start,
           m_slave, m_rw, m_reg_addr, m_send_data}, 64'd0);
      prev_busy = iic_busy;
      return;
    end
    if (req_ack != '0) begin
      chk("ack_onehot", 64'($countones(req_ack)), 64'd1);
      for (int i = 0; i < N; i++) if (req_ack[i]) acked[i]++;
      if (ackq.size() == 0) begin
        chk("ack_unexpected", 64'(req_ack), 64'd0);
      end else begin
        e = ackq.pop_front();
        oh = '0;
        oh[e.idx] = 1'b1;
        chk("ack_idx", 64'(req_ack), 64'(oh));
        chk("ack_fields", {m_rw, m_slave, m_reg_addr, m_send_data},
            {e.rw, e.slave, e.addr, e.wdata});
        chk("ack_master_idle", 64'(prev_busy), 64'd0);
        cur = e;
      end
      ack_cyc = cyc;
    end
    if (iic_start) begin
      chk("start_after_ack", 64'(cyc - ack_cyc), 64'd1);
      chk("start_fields", {m_rw, m_slave, m_reg_addr, m_send_data},
          {cur.rw, cur.slave, cur.addr, cur.wdata});
      start_cyc = cyc;
    end
    if (rsp_valid != '0) begin
      if (rspq.size() == 0) begin
        chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        r = rspq.pop_front();
        oh = '0;
        oh[r.idx] = 1'b1;
        chk("rsp_idx", 64'(rsp_valid), 64'(oh));
        chk("rsp_err", 64'(rsp_err), 64'(r.err));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(r.rdata));
        chk("rsp_fields_held", {m_rw, m_slave, m_reg_addr, m_send_data},
            {cur.rw, cur.slave, cur.addr, cur.wdata});
        if (r.err) chk("timeout_latency", 64'(cyc - start_cyc), 64'(TO));
      end
    end
    prev_busy = iic_busy;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_quiet(input int budget);
    int c = 0;
    while ((ackq.size() != 0 || rspq.size() != 0 || arb_busy) && c < budget) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    chk("quiet_reached", 64'(ackq.size() + rspq.size() + int'(arb_busy)), 64'd0);
  endtask

  task automatic stimulus();
    int c;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'h00, 16'h0000, 8'h00);
    bfm_dead  = 1'b0;
    bfm_rdata = 8'h00;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single write from requester 0
    set_req(0, 1'b0, 8'hA0, 16'h0012, 8'h5A);
    push_ack(0); push_rsp(0, 1'b0, 8'h00);
    issued[0]++;
    wait_quiet(200);

    // Read from requester 1
    bfm_rdata = 8'h5A;
    set_req(1, 1'b1, 8'hA1, 16'h0012, 8'h00);
    push_ack(1); push_rsp(1, 1'b0, 8'h5A);
    issued[1]++;
    wait_quiet(200);

    // Fairness from a fresh pointer: all three continuously valid
    do_reset(2);
    @(negedge clk);
    bfm_rdata = 8'hC3;
    set_req(0, 1'b0, 8'h10, 16'h0100, 8'h11);
    set_req(1, 1'b1, 8'h20, 16'h0200, 8'h22);
    set_req(2, 1'b0, 8'h30, 16'h0300, 8'h33);
    for (int k = 0; k < 2; k++) begin
      push_ack(0); push_ack(1); push_ack(2);
      push_rsp(0, 1'b0, 8'h00); push_rsp(1, 1'b0, 8'hC3); push_rsp(2, 1'b0, 8'h00);
    end
    for (int i = 0; i < N; i++) issued[i] += 2;
    wait_quiet(1000);

    // Busy never rises: timeout error, read data forced to zero
    bfm_dead = 1'b1;
    set_req(2, 1'b1, 8'h50, 16'h0345, 8'h00);
    push_ack(2); push_rsp(2, 1'b1, 8'h00);
    issued[2]++;
    wait_quiet(200);
    bfm_dead = 1'b0;

    // Reset while the master is mid-transfer: no response, next grant waits for idle master
    set_req(0, 1'b0, 8'h60, 16'h0400, 8'h44);
    push_ack(0);
    issued[0]++;
    c = 0;
    while (!iic_busy && c < 100) begin @(negedge clk); c++; end
    chk("bfm_busy_seen", 64'(iic_busy), 64'd1);
    repeat (3) @(negedge clk);
    do_reset(2);
    bfm_rdata = 8'h9C;
    set_req(1, 1'b1, 8'h70, 16'h0500, 8'h00);
    push_ack(1); push_rsp(1, 1'b0, 8'h9C);
    issued[1]++;
    @(negedge clk);
    chk("no_grant_while_master_busy", {63'd0, req_ack != '0}, 64'd0);
    wait_quiet(300);

    // Withdraw: requester 0 pulses valid for one cycle while arbiter is busy
    set_req(2, 1'b0, 8'h80, 16'h0600, 8'h66);
    push_ack(2); push_rsp(2, 1'b0, 8'h00);
    issued[2]++;
    c = 0;
    while (ackq.size() != 0 && c < 100) begin @(negedge clk); c++; end
    set_req(0, 1'b1, 8'hEE, 16'h0EEE, 8'hEE);
    issued[0]++;
    @(negedge clk);
    issued[0]--;
    set_req(1, 1'b1, 8'h90, 16'h0700, 8'h00);
    push_ack(1); push_rsp(1, 1'b0, 8'h9C);
    issued[1]++;
    wait_quiet(300);
    repeat (10) @(negedge clk);
    chk("queues_drained", 64'(ackq.size() + rspq.size()), 64'd0);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
      stimulus();
    join_any
    disable fork;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
